enigma_step_controller: RTL and testbench
=========================================

Name: enigma_step_controller

Overview:
- Sequencer between the PS/2 keyboard front end and the combinational Enigma datapath (plugboard, rotor, rotor2, reflector and the return path).
- Detects each new keypress and latches the one-hot letter.
- Steps the two rotor positions with notch carry, then holds the letter on the datapath for a settle window.
- Captures the 5-bit result and hands it to downstream consumers (VGA display, Morse decoder) with a valid/ready handshake.
- Replaces free-running rotation on the level `press` signal.

Parameters:
- NOTCH0, 16: rotor0 position (0..25) at which the next step also carries into rotor1 (16 = 'Q').
- SETTLE_CYCLES, 4: clock cycles the letter is held on `enc_in` after stepping before `enc_result` is sampled; legal range 1..255.
- NUM_LETTERS, 26: alphabet size and rotor modulus.

Ports:
- clock  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  keyboard `ready` level; a rising edge means a new key.
- key_letter  in  26  one-hot letter from the keyboard, bit0 = A.
- set  in  1  synchronous load of rotor positions; active high.
- set_pos0  in  5  rotor0 load value.
- set_pos1  in  5  rotor1 load value.
- pos0  out  5  current rotor0 position, 0..25.
- pos1  out  5  current rotor1 position, 0..25.
- enc_in  out  26  one-hot letter driven into the datapath; all-zero when not encrypting.
- enc_result  in  5  datapath output index; 31 = invalid.
- out_letter  out  5  captured ciphertext index.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts `out_letter`.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  one-cycle pulse on a rejected key or an invalid result.

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE.
  - pos0, pos1, out_letter = 0.
  - enc_in = 0.
  - out_valid, busy, err = 0.
  - Edge-detect register = 0.
- Key event: `key_valid` registered once; event = key_valid & ~key_valid_q.
- FSM states:
  - IDLE:
    - On event with `key_letter` exactly one-hot: latch letter and go to STEP.
    - On event with `key_letter` zero or multi-hot: err = 1 for one cycle, stay in IDLE.
  - STEP (1 cycle):
    - pos0 <= (pos0 == 25) ? 0 : pos0 + 1.
    - If the pre-step pos0 == NOTCH0, pos1 steps the same way; otherwise pos1 holds.
    - Load the settle counter with SETTLE_CYCLES and go to SETTLE.
  - SETTLE:
    - enc_in = latched letter.
    - Counter decrements each cycle; at 1, go to CAPTURE.
  - CAPTURE (1 cycle):
    - Sample enc_result while enc_in is still driven.
    - If the value is ≥ 26: err = 1 and go to IDLE with no output.
    - Otherwise: out_letter <= enc_result, out_valid <= 1, go to OUT_WAIT.
  - OUT_WAIT:
    - out_valid held and out_letter stable.
    - When out_valid & out_ready: out_valid <= 0 on the next edge and go to IDLE.
    - enc_in is 0 in this state.
- Latency: from the event cycle to out_valid is SETTLE_CYCLES + 3 edges (default 7).
- Key events arriving while busy (without the optional feature) are dropped silently.
- `set` has priority over everything, in any state:
  - pos0 <= set_pos0, or 0 if set_pos0 ≥ 26; pos1 likewise.
  - FSM aborts to IDLE; out_valid and enc_in are cleared; any pending key is discarded.
- Key event and `set` in the same cycle: `set` wins and the key is dropped.
- Wrap-around: 25 → 0 on both rotors. pos0 = 25 with NOTCH0 = 25 gives pos0 = 0 and pos1 steps.
- Reset asserted mid-operation returns all outputs to reset values immediately.

Optional Feature:
- Macro ENIGMA_KEY_QUEUE_EN.
- When defined: a one-entry pending buffer holds a valid one-hot key that arrives while busy.
  - On returning to IDLE, a pending key enters STEP on the next cycle without a new event.
  - A second key arriving while the buffer is full: err pulse, key dropped.
- When undefined: no buffer; busy-time keys are dropped and err is not pulsed.

Decomposition:
- Shared package `enigma_pkg`:
  - NUM_LETTERS.
  - Letter index typedef (5-bit).
  - INVALID_IDX = 31.
  - FSM state enum {IDLE, STEP, SETTLE, CAPTURE, OUT_WAIT}.
  - A function returning one-hot validity.
- One natural sub-module, `rotor_position_counter`: mod-26 counter with step/load inputs and a carry-out flag.
  - Instantiated twice, chained through the carry-out; pos1 is stepped by (step & pos0 == NOTCH0).

Test Plan:
- Reset, then key 'A' (bit0) with enc_result = 7 and out_ready = 1 → pos0 = 1, pos1 = 0; out_valid rises 7 edges after the event with out_letter = 7; enc_in = 26'h1 only during SETTLE/CAPTURE.
- set_pos0 = 16, set_pos1 = 3, then one key → pos0 = 17, pos1 = 4. Then set_pos0 = 25, set_pos1 = 25, one key → pos0 = 0, pos1 = 25.
- key_letter = 26'h3 (two bits hot) → err pulses once, pos0 unchanged, no out_valid.
- out_ready held at 0 for 10 cycles → out_valid and out_letter stable throughout; the cycle after out_ready = 1, out_valid = 0.
- enc_result = 31 during CAPTURE → err = 1, no out_valid, FSM back in IDLE.
- Second key event during SETTLE:
  - Macro off → dropped, pos0 advances by 1 total.
  - Macro on → both processed, pos0 advances by 2 and two out_valid handshakes complete.
  - Plus: `set` asserted during OUT_WAIT → out_valid cleared, positions loaded.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma step controller.
// Letters travel either as a 26-bit one-hot vector (bit0 = 'A') or as a
// 5-bit index where 31 marks "no valid letter".
package enigma_pkg;

  localparam int NUM_LETTERS = 26;

  typedef logic [4:0]             letter_idx_t;
  typedef logic [NUM_LETTERS-1:0] letter_onehot_t;

  localparam letter_idx_t INVALID_IDX = 5'd31;
  localparam letter_idx_t LAST_IDX    = letter_idx_t'(NUM_LETTERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    CAPTURE,
    OUT_WAIT
  } state_t;

  // True when exactly one bit is set; clearing the lowest set bit of a
  // one-hot vector leaves zero.
  function automatic logic is_one_hot(input letter_onehot_t v);
    return (v != '0) && ((v & (v - letter_onehot_t'(1))) == '0);
  endfunction

  // True when an index names a real letter (0..25).
  function automatic logic is_valid_idx(input letter_idx_t i);
    return i <= LAST_IDX;
  endfunction

endpackage

// File: rtl/rotor_position_counter.sv
// Mod-26 rotor position counter.
// A load takes priority over a step and clamps out-of-range values to 0.
// o_carry flags that this step passes the notch, so the next rotor in the
// chain should step on the same edge.
module rotor_position_counter
  import enigma_pkg::*;
#(
  parameter int NOTCH = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_step,
  input  logic        i_load,
  input  letter_idx_t i_load_val,
  output letter_idx_t o_pos,
  output logic        o_carry
);

  localparam letter_idx_t NOTCH_IDX = letter_idx_t'(NOTCH);

  letter_idx_t r_pos;

  assign o_pos   = r_pos;
  assign o_carry = i_step & (r_pos == NOTCH_IDX);

  // Position register: load, else step with wrap 25 -> 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pos <= '0;
    end else if (i_load) begin
      r_pos <= is_valid_idx(i_load_val) ? i_load_val : '0;
    end else if (i_step) begin
      r_pos <= (r_pos == LAST_IDX) ? '0 : r_pos + 5'd1;
    end
  end

endmodule

// File: rtl/enigma_step_controller.sv
// Keypress sequencer for the combinational Enigma datapath.
// Each rising edge of key_valid with a one-hot letter steps the rotors,
// holds the letter on enc_in for SETTLE_CYCLES, captures enc_result and
// offers it downstream on an out_valid/out_ready handshake.
// `set` loads the rotor positions and aborts any operation in progress.
// Optional feature macro: ENIGMA_KEY_QUEUE_EN -- one-entry buffer for a key
// that arrives while the sequencer is busy.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int NOTCH0        = 16,
  parameter int SETTLE_CYCLES = 4   // 1..255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [25:0] key_letter,
  input  logic        set,
  input  logic [4:0]  set_pos0,
  input  logic [4:0]  set_pos1,
  output logic [4:0]  pos0,
  output logic [4:0]  pos1,
  output logic [25:0] enc_in,
  input  logic [4:0]  enc_result,
  output logic [4:0]  out_letter,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        err
);

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);

  state_t         r_state;
  logic           r_key_q;
  letter_onehot_t r_letter;
  letter_onehot_t r_enc_in;
  logic [7:0]     r_cnt;
  letter_idx_t    r_out_letter;
  logic           r_out_valid;
  logic           r_busy;
  logic           r_err;

`ifdef ENIGMA_KEY_QUEUE_EN
  logic           r_pend_valid;
  letter_onehot_t r_pend_letter;
`endif

  logic        w_event;
  logic        w_key_ok;
  logic        w_step0;
  logic        w_carry0;
  logic        w_unused_carry1;
  letter_idx_t w_pos0;
  letter_idx_t w_pos1;

  assign w_event  = key_valid & ~r_key_q;
  assign w_key_ok = is_one_hot(key_letter);
  // A set on the STEP cycle aborts, so the rotors must not advance either.
  assign w_step0  = (r_state == STEP) & ~set;

  // Rotor0 always steps; rotor1 steps only when rotor0 passes its notch.
  rotor_position_counter #(.NOTCH(NOTCH0)) u_rotor0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_step     (w_step0),
    .i_load     (set),
    .i_load_val (set_pos0),
    .o_pos      (w_pos0),
    .o_carry    (w_carry0)
  );

  rotor_position_counter #(.NOTCH(NUM_LETTERS - 1)) u_rotor1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_step     (w_carry0),
    .i_load     (set),
    .i_load_val (set_pos1),
    .o_pos      (w_pos1),
    .o_carry    (w_unused_carry1)
  );

  // Edge detector on the keyboard ready level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_key_q <= 1'b0;
    end else begin
      r_key_q <= key_valid;
    end
  end

  // Sequencer FSM with registered outputs; set overrides every state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_letter     <= '0;
      r_enc_in     <= '0;
      r_cnt        <= '0;
      r_out_letter <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
`ifdef ENIGMA_KEY_QUEUE_EN
      r_pend_valid  <= 1'b0;
      r_pend_letter <= '0;
`endif
    end else begin
      // err is a single-cycle pulse unless a branch below raises it again.
      r_err <= 1'b0;
      if (set) begin
        r_state     <= IDLE;
        r_enc_in    <= '0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
        r_busy      <= 1'b0;
`ifdef ENIGMA_KEY_QUEUE_EN
        r_pend_valid <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
`ifdef ENIGMA_KEY_QUEUE_EN
            if (r_pend_valid) begin
              // The buffered key starts now; a fresh key refills the buffer.
              r_letter     <= r_pend_letter;
              r_state      <= STEP;
              r_busy       <= 1'b1;
              r_pend_valid <= w_event & w_key_ok;
              if (w_event && w_key_ok) begin
                r_pend_letter <= key_letter;
              end
              if (w_event && !w_key_ok) begin
                r_err <= 1'b1;
              end
            end else
`endif
            if (w_event) begin
              if (w_key_ok) begin
                r_letter <= key_letter;
                r_state  <= STEP;
                r_busy   <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          STEP: begin
            r_cnt    <= SETTLE_INIT;
            r_enc_in <= r_letter;
            r_state  <= SETTLE;
          end
          SETTLE: begin
            if (r_cnt <= 8'd1) begin
              r_state <= CAPTURE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          CAPTURE: begin
            r_enc_in <= '0;
            if (is_valid_idx(enc_result)) begin
              r_out_letter <= enc_result;
              r_out_valid  <= 1'b1;
              r_state      <= OUT_WAIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          OUT_WAIT: begin
            if (out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_enc_in <= '0;
            r_busy   <= 1'b0;
          end
        endcase
`ifdef ENIGMA_KEY_QUEUE_EN
        // Keys arriving mid-operation are buffered once; overflow or a bad
        // code is reported.
        if (r_state != IDLE && w_event) begin
          if (w_key_ok && !r_pend_valid) begin
            r_pend_valid  <= 1'b1;
            r_pend_letter <= key_letter;
          end else begin
            r_err <= 1'b1;
          end
        end
`endif
      end
    end
  end

  assign pos0       = w_pos0;
  assign pos1       = w_pos1;
  assign enc_in     = r_enc_in;
  assign out_letter = r_out_letter;
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for enigma_step_controller with a scoreboard of expected
// ciphertext indices and a behavioural stand-in for the Enigma datapath.
module tb_enigma_step_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        key_valid;
  logic [25:0] key_letter;
  logic        set;
  logic [4:0]  set_pos0;
  logic [4:0]  set_pos1;
  logic [4:0]  pos0;
  logic [4:0]  pos1;
  logic [25:0] enc_in;
  logic [4:0]  enc_result;
  logic [4:0]  out_letter;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int sb[$];

  // Datapath stand-in: constant mode, or (letter + pos0 + pos1) mod 26.
  int          dp_mode;
  logic [4:0]  dp_const;

  // Expected rotor positions.
  int ep0 = 0;
  int ep1 = 0;

  always #5 clock = ~clock;

  enigma_step_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_letter (key_letter),
    .set        (set),
    .set_pos0   (set_pos0),
    .set_pos1   (set_pos1),
    .pos0       (pos0),
    .pos1       (pos1),
    .enc_in     (enc_in),
    .enc_result (enc_result),
    .out_letter (out_letter),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err)
  );

  function automatic int idx_of(input logic [25:0] v);
    for (int i = 0; i < 26; i++) begin
      if (v[i]) return i;
    end
    return 31;
  endfunction

  function automatic int next_pos(input int p);
    return (p == 25) ? 0 : p + 1;
  endfunction

  always_comb begin
    if (dp_mode == 0) begin
      enc_result = dp_const;
    end else if (enc_in == '0) begin
      enc_result = 5'd31;
    end else begin
      enc_result = 5'((idx_of(enc_in) + int'(pos0) + int'(pos1)) % 26);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance the expected rotor model and return the expected ciphertext.
  task automatic step_model(input logic [25:0] l, output int exp);
    if (ep0 == 16) ep1 = next_pos(ep1);
    ep0 = next_pos(ep0);
    exp = (idx_of(l) + ep0 + ep1) % 26;
  endtask

  // Raise key_valid for one edge (the event edge), then drop it.
  task automatic press_key(input logic [25:0] l);
    key_valid  = 1'b1;
    key_letter = l;
    tick();
    key_valid  = 1'b0;
  endtask

  task automatic load_pos(input logic [4:0] p0, input logic [4:0] p1);
    set      = 1'b1;
    set_pos0 = p0;
    set_pos1 = p1;
    tick();
    set = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    check("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard monitor: every completed handshake pops one expected letter.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("out_letter", 32'(out_letter), 32'(sb.pop_front()));
      end
      n_out++;
    end
  end

  initial begin
    int exp;
    int first_valid;
    int err_cnt;
    int err_edge;
    int valid_cnt;

    reset_n    = 1'b0;
    key_valid  = 1'b0;
    key_letter = '0;
    set        = 1'b0;
    set_pos0   = '0;
    set_pos1   = '0;
    out_ready  = 1'b1;
    dp_mode    = 0;
    dp_const   = 5'd7;

    // Reset values.
    repeat (3) tick();
    check("rst_pos0", 32'(pos0), 32'd0);
    check("rst_pos1", 32'(pos1), 32'd0);
    check("rst_enc_in", 32'(enc_in), 32'd0);
    check("rst_out_letter", 32'(out_letter), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();

    // Key 'A' with a constant result of 7: latency and enc_in window.
    step_model(26'h1, exp);
    sb.push_back(7);
    press_key(26'h1);
    check("a_busy", 32'(busy), 32'd1);
    check("a_enc_e1", 32'(enc_in), 32'd0);
    first_valid = 0;
    for (int e = 2; e <= 9; e++) begin
      tick();
      check("a_enc_window", 32'(enc_in), (e >= 2 && e <= 6) ? 32'h1 : 32'h0);
      if (out_valid && first_valid == 0) first_valid = e;
    end
    check("a_latency", 32'(first_valid), 32'd7);
    wait_idle(20);
    check("a_pos0", 32'(pos0), 32'd1);
    check("a_pos1", 32'(pos1), 32'd0);

    // Notch carry: 16,3 -> 17,4.
    dp_mode = 1;
    load_pos(5'd16, 5'd3);
    ep0 = 16; ep1 = 3;
    check("set_pos0", 32'(pos0), 32'd16);
    check("set_pos1", 32'(pos1), 32'd3);
    step_model(26'h4, exp);
    sb.push_back(exp);
    press_key(26'h4);
    wait_idle(20);
    check("notch_pos0", 32'(pos0), 32'd17);
    check("notch_pos1", 32'(pos1), 32'd4);

    // pos0 wrap without carry: 25,25 -> 0,25.
    load_pos(5'd25, 5'd25);
    ep0 = 25; ep1 = 25;
    step_model(26'h2000000, exp);
    sb.push_back(exp);
    press_key(26'h2000000);
    wait_idle(20);
    check("wrap_pos0", 32'(pos0), 32'd0);
    check("wrap_pos1", 32'(pos1), 32'd25);

    // Out-of-range load values clamp to 0.
    load_pos(5'd30, 5'd27);
    ep0 = 0; ep1 = 0;
    check("clamp_pos0", 32'(pos0), 32'd0);
    check("clamp_pos1", 32'(pos1), 32'd0);

    // Multi-hot and empty keys are rejected with a single err pulse.
    press_key(26'h3);
    check("multi_err", 32'(err), 32'd1);
    check("multi_busy", 32'(busy), 32'd0);
    tick();
    check("multi_err_end", 32'(err), 32'd0);
    press_key(26'h0);
    check("zero_err", 32'(err), 32'd1);
    tick();
    check("reject_pos0", 32'(pos0), 32'd0);
    check("reject_nout", 32'(n_out), 32'd3);

    // Backpressure: output held stable for 10 cycles.
    out_ready = 1'b0;
    step_model(26'h2, exp);
    sb.push_back(exp);
    press_key(26'h2);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_letter", 32'(out_letter), 32'(exp));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", 32'(out_valid), 32'd0);
    wait_idle(5);

    // Invalid datapath result: err at the capture edge, no output.
    dp_mode  = 0;
    dp_const = 5'd31;
    step_model(26'h8, exp);
    press_key(26'h8);
    err_cnt = 0; err_edge = 0; valid_cnt = 0;
    for (int e = 2; e <= 10; e++) begin
      tick();
      if (err) begin
        err_cnt++;
        err_edge = e;
      end
      if (out_valid) valid_cnt++;
    end
    check("inv_err_cnt", 32'(err_cnt), 32'd1);
    check("inv_err_edge", 32'(err_edge), 32'd7);
    check("inv_no_valid", 32'(valid_cnt), 32'd0);
    check("inv_busy", 32'(busy), 32'd0);
    check("inv_pos0", 32'(pos0), 32'(ep0));

    // Second key during SETTLE.
    dp_mode = 1;
    step_model(26'h10, exp);
    sb.push_back(exp);
    press_key(26'h10);
    tick();
`ifdef ENIGMA_KEY_QUEUE_EN
    step_model(26'h20, exp);
    sb.push_back(exp);
`endif
    press_key(26'h20);
    repeat (30) tick();
    check("dbl_pos0", 32'(pos0), 32'(ep0));
    check("dbl_busy", 32'(busy), 32'd0);
`ifdef ENIGMA_KEY_QUEUE_EN
    check("dbl_nout", 32'(n_out), 32'd6);
`else
    check("dbl_nout", 32'(n_out), 32'd5);
`endif

    // set during OUT_WAIT aborts and loads positions.
    out_ready = 1'b0;
    step_model(26'h1, exp);
    press_key(26'h1);
    wait_valid(20);
    check("ow_letter", 32'(out_letter), 32'(exp));
    load_pos(5'd5, 5'd6);
    ep0 = 5; ep1 = 6;
    check("ow_valid_clr", 32'(out_valid), 32'd0);
    check("ow_busy", 32'(busy), 32'd0);
    check("ow_enc_in", 32'(enc_in), 32'd0);
    check("ow_pos0", 32'(pos0), 32'd5);
    check("ow_pos1", 32'(pos1), 32'd6);
    out_ready = 1'b1;

    // Key and set in the same cycle: set wins, key dropped without err.
    key_valid  = 1'b1;
    key_letter = 26'h1;
    load_pos(5'd10, 5'd11);
    key_valid = 1'b0;
    ep0 = 10; ep1 = 11;
    check("kset_busy", 32'(busy), 32'd0);
    check("kset_err", 32'(err), 32'd0);
    tick();
    check("kset_busy2", 32'(busy), 32'd0);
    check("kset_pos0", 32'(pos0), 32'd10);

    // Carry into rotor1 with rotor1 wrapping: 16,25 -> 17,0.
    load_pos(5'd16, 5'd25);
    ep0 = 16; ep1 = 25;
    step_model(26'h1, exp);
    sb.push_back(exp);
    press_key(26'h1);
    wait_idle(20);
    check("c1wrap_pos0", 32'(pos0), 32'd17);
    check("c1wrap_pos1", 32'(pos1), 32'd0);

    // Reset asserted mid-operation clears outputs immediately.
    press_key(26'h1);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_enc_in", 32'(enc_in), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pos0", 32'(pos0), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
